// File: rtl/vga_pkg.sv
// Shared VGA pattern definitions: default geometry, pattern codes and colour constants.
// Colours are packed {r,g,b}, 8 bits per channel.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  typedef enum logic [1:0] {
    PAT_SOLID = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_BOX   = 2'd3
  } pattern_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t COL_WHITE   = 24'hFF_FF_FF;
  localparam rgb_t COL_YELLOW  = 24'hFF_FF_00;
  localparam rgb_t COL_CYAN    = 24'h00_FF_FF;
  localparam rgb_t COL_GREEN   = 24'h00_FF_00;
  localparam rgb_t COL_MAGENTA = 24'hFF_00_FF;
  localparam rgb_t COL_RED     = 24'hFF_00_00;
  localparam rgb_t COL_BLUE    = 24'h00_00_FF;
  localparam rgb_t COL_BLACK   = 24'h00_00_00;

  function automatic rgb_t bar_colour(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = COL_WHITE;
      3'd1:    c = COL_YELLOW;
      3'd2:    c = COL_CYAN;
      3'd3:    c = COL_GREEN;
      3'd4:    c = COL_MAGENTA;
      3'd5:    c = COL_RED;
      3'd6:    c = COL_BLUE;
      default: c = COL_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position: each axis steps by BOX_STEP per frame tick, clamping to
// [0, limit] and reversing direction whenever it reaches or would pass an edge.
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int PW       = 10,
  parameter int BOX_STEP = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_tick,
  input  logic [PW-1:0] x_limit,
  input  logic [PW-1:0] y_limit,
  output logic [PW-1:0] box_x,
  output logic [PW-1:0] box_y
);

  logic          dir_x;
  logic          dir_y;
  logic [PW:0]   next_x;
  logic [PW:0]   next_y;

  // Returns {flip, new_pos}; arithmetic is one bit wider so the step never wraps.
  function automatic logic [PW:0] next_axis(input logic [PW-1:0] pos,
                                            input logic          up,
                                            input logic [PW-1:0] lim);
    logic [PW:0] pos_w;
    logic [PW:0] step_w;
    logic [PW:0] res;
    pos_w  = {1'b0, pos};
    step_w = (PW+1)'(BOX_STEP);
    if (up) begin
      if (pos_w + step_w >= {1'b0, lim}) res = {1'b1, lim};
      else                               res = {1'b0, pos + PW'(BOX_STEP)};
    end else begin
      if (pos_w <= step_w) res = {1'b1, {PW{1'b0}}};
      else                 res = {1'b0, pos - PW'(BOX_STEP)};
    end
    return res;
  endfunction

  assign next_x = next_axis(box_x, dir_x, x_limit);
  assign next_y = next_axis(box_y, dir_y, y_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      box_x <= '0;
      box_y <= '0;
      dir_x <= 1'b1;
      dir_y <= 1'b1;
    end else if (frame_tick) begin
      box_x <= next_x[PW-1:0];
      box_y <= next_y[PW-1:0];
      dir_x <= dir_x ^ next_x[PW];
      dir_y <= dir_y ^ next_y[PW];
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Pixel-colour stage after the VGA sync generator: rebuilds x/y from video_on and
// emits RGB test patterns with syncs delayed to match (2-cycle latency, no stalls).
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE           = DEF_H_ACTIVE,
  parameter int V_ACTIVE           = DEF_V_ACTIVE,
  parameter int FRAMES_PER_PATTERN = 120,
  parameter int BOX_SIZE           = 32,
  parameter int BOX_STEP           = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       video_on_in,
  input  logic       auto_cycle,
  input  logic [1:0] pattern_sel,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       frame_tick
);

  localparam int XW    = $clog2(H_ACTIVE + 1);
  localparam int YW    = $clog2(V_ACTIVE + 1);
  localparam int PW    = (XW > YW) ? XW : YW;
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = $clog2(BAR_W + 1);
  localparam int FW    = $clog2(FRAMES_PER_PATTERN + 1);

  logic           hs1;
  logic           vs1;
  logic           von1;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [BW-1:0]  bar_cnt;
  logic [2:0]     bar_idx;
  logic [FW-1:0]  frame_cnt;
  pattern_t       pattern;
  logic [PW-1:0]  box_x;
  logic [PW-1:0]  box_y;

  logic           frame_start;
  logic           line_end;
  logic           line_run;
  logic [PW:0]    px;
  logic [PW:0]    py;
  logic [PW:0]    bx_lo;
  logic [PW:0]    by_lo;
  logic           in_box;
  rgb_t           colour;

  assign frame_start = vs1 & ~vsync_in;
  assign line_end    = von1 & ~video_on_in;
  assign line_run    = von1 & video_on_in;

  // Stage 1: registered sync inputs and the frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs1        <= 1'b1;
      vs1        <= 1'b1;
      von1       <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      hs1        <= hsync_in;
      vs1        <= vsync_in;
      von1       <= video_on_in;
      frame_tick <= frame_start;
    end
  end

  // x and the bar sub-counter describe the pixel now held in stage 1; a line's
  // first pixel (von1 was low) always lands on 0, which also clears after a line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x       <= '0;
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (line_run) begin
      x <= x + XW'(1);
      if (bar_cnt == BW'(BAR_W - 1)) begin
        bar_cnt <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_cnt <= bar_cnt + BW'(1);
      end
    end else begin
      x       <= '0;
      bar_cnt <= '0;
      bar_idx <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= '0;
    end else if (frame_start) begin
      y <= '0;
    end else if (line_end) begin
      y <= y + YW'(1);
    end
  end

  // Pattern only changes at frame start; manual mode holds the dwell counter at 0
  // so re-entering auto mode always gives the first pattern a full dwell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern   <= PAT_SOLID;
      frame_cnt <= '0;
    end else if (!auto_cycle) begin
      frame_cnt <= '0;
      if (frame_start) pattern <= pattern_t'(pattern_sel);
    end else if (frame_start) begin
      if (frame_cnt == FW'(FRAMES_PER_PATTERN - 1)) begin
        frame_cnt <= '0;
        pattern   <= pattern_t'(pattern + 2'd1);
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

  vga_box_mover #(
    .PW       (PW),
    .BOX_STEP (BOX_STEP)
  ) u_box (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_start),
    .x_limit    (PW'(H_ACTIVE - BOX_SIZE)),
    .y_limit    (PW'(V_ACTIVE - BOX_SIZE)),
    .box_x      (box_x),
    .box_y      (box_y)
  );

  assign px    = (PW+1)'(x);
  assign py    = (PW+1)'(y);
  assign bx_lo = {1'b0, box_x};
  assign by_lo = {1'b0, box_y};

  always_comb begin
    in_box = (px >= bx_lo) && (px < bx_lo + (PW+1)'(BOX_SIZE)) &&
             (py >= by_lo) && (py < by_lo + (PW+1)'(BOX_SIZE));
  end

  always_comb begin
    colour = COL_BLACK;
    unique case (pattern)
      PAT_SOLID: colour = COL_RED;
      PAT_BARS:  colour = bar_colour(bar_idx);
      PAT_CHECK: colour = (x[5] ^ y[5]) ? COL_BLACK : COL_WHITE;
      PAT_BOX:   colour = in_box ? COL_WHITE : COL_BLUE;
      default:   colour = COL_BLACK;
    endcase
  end

  // Stage 2: colour and delayed syncs; blanking overrides every pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      hsync <= hs1;
      vsync <= vs1;
      if (von1) begin
        red   <= colour.r;
        green <= colour.g;
        blue  <= colour.b;
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen on a reduced 64x36 raster, captured frame by frame.
module tb_vga_pattern_gen;

  localparam int H    = 64;
  localparam int V    = 36;
  localparam int HB   = 4;
  localparam int LINE = H + HB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic       video_on_in = 1'b0;
  logic       auto_cycle = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic       hsync;
  logic       vsync;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       frame_tick;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  int sync_err, blank_err, tick_err, tick_cnt;
  logic h_hs [2];
  logic h_vs [2];
  logic h_von [2];
  int   h_x [2];
  int   h_y [2];
  logic [23:0] cap [V][H];

  typedef struct { int y; int x; logic [23:0] c; } pt_t;

  vga_pattern_gen #(
    .H_ACTIVE           (H),
    .V_ACTIVE           (V),
    .FRAMES_PER_PATTERN (2),
    .BOX_SIZE           (8),
    .BOX_STEP           (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .video_on_in (video_on_in),
    .auto_cycle  (auto_cycle),
    .pattern_sel (pattern_sel),
    .hsync       (hsync),
    .vsync       (vsync),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .frame_tick  (frame_tick)
  );

  always #20 clk = ~clk;

  // One clock: check outputs against the inputs driven two cycles ago, then drive.
  task automatic step(input logic hs, input logic vs, input logic von, input int pxl, input int pyl);
    @(posedge clk);
    #1;
    if (chk_en) begin
      if (hsync !== h_hs[1] || vsync !== h_vs[1]) sync_err++;
      if (frame_tick !== (h_vs[1] & ~h_vs[0])) tick_err++;
      if (frame_tick === 1'b1) tick_cnt++;
      if (h_von[1]) cap[h_y[1]][h_x[1]] = {red, green, blue};
      else if ({red, green, blue} !== 24'h0) blank_err++;
    end
    h_hs[1] = h_hs[0];   h_hs[0] = hs;
    h_vs[1] = h_vs[0];   h_vs[0] = vs;
    h_von[1] = h_von[0]; h_von[0] = von;
    h_x[1] = h_x[0];     h_x[0] = pxl;
    h_y[1] = h_y[0];     h_y[0] = pyl;
    hsync_in = hs;
    vsync_in = vs;
    video_on_in = von;
  endtask

  task automatic drive_line(input logic vs, input logic act, input int pyl);
    for (int c = 0; c < LINE; c++)
      step((c == H + 1 || c == H + 2) ? 1'b0 : 1'b1, vs, act && (c < H), (c < H) ? c : 0, pyl);
  endtask

  task automatic run_frame(input int chg_line, input logic [1:0] chg_sel);
    sync_err = 0; blank_err = 0; tick_err = 0; tick_cnt = 0;
    for (int yy = 0; yy < V; yy++)
      for (int xx = 0; xx < H; xx++) cap[yy][xx] = 'x;
    drive_line(1'b1, 1'b0, 0);
    drive_line(1'b0, 1'b0, 0);
    for (int yy = 0; yy < V; yy++) begin
      if (yy == chg_line) pattern_sel = chg_sel;
      drive_line(1'b1, 1'b1, yy);
    end
  endtask

  task automatic pulse_reset;
    chk_en = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 0, 0);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 0, 0);
    chk_en = 1'b1;
  endtask

  function automatic int classify();
    if (cap[0][20] === 24'h00FFFF) return 1;
    if (cap[0][0] === 24'hFF0000) return 0;
    if (cap[0][0] === 24'hFFFFFF && cap[0][40] === 24'h000000) return 2;
    if (cap[0][0] === 24'hFFFFFF || cap[0][0] === 24'h0000FF) return 3;
    return 7;
  endfunction

  task automatic test_reset;
    int e_sync = 0, e_rgb = 0, e_tick = 0;
    rst_n = 1'b0;
    chk_en = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step((i % 9 < 2) ? 1'b0 : 1'b1, (i % 60 < 12) ? 1'b0 : 1'b1, (i % 9 >= 3) ? 1'b1 : 1'b0, 0, 0);
      if (hsync !== 1'b1 || vsync !== 1'b1) e_sync++;
      if ({red, green, blue} !== 24'h0) e_rgb++;
      if (frame_tick !== 1'b0) e_tick++;
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 0, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 0, 0);
    tests++; if (e_sync != 0) begin fails++; $display("FAIL reset_sync: %0d cycles not high, required 0", e_sync); end
    tests++; if (e_rgb != 0) begin fails++; $display("FAIL reset_rgb: %0d cycles nonzero, required 0", e_rgb); end
    tests++; if (e_tick != 0) begin fails++; $display("FAIL reset_tick: %0d pulses, required 0", e_tick); end
    pattern_sel = 2'd0;
    run_frame(-1, 2'd0);
    tests++; if (tick_cnt != 1) begin fails++; $display("FAIL first_tick_count: got %0d, required 1", tick_cnt); end
    tests++; if (tick_err != 0) begin fails++; $display("FAIL first_tick_timing: %0d misplaced cycles, required 0", tick_err); end
  endtask

  task automatic test_solid;
    int bad = 0;
    pattern_sel = 2'd0;
    run_frame(-1, 2'd0);
    for (int yy = 0; yy < V; yy++)
      for (int xx = 0; xx < H; xx++)
        if (cap[yy][xx] !== 24'hFF0000) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL solid_pixels: %0d not FF0000, required 0", bad); end
    tests++; if (blank_err != 0) begin fails++; $display("FAIL solid_blank: %0d nonzero blank cycles, required 0", blank_err); end
    tests++; if (sync_err != 0) begin fails++; $display("FAIL solid_sync_delay: %0d cycles differ, required 0", sync_err); end
    tests++; if (tick_err != 0 || tick_cnt != 1) begin fails++; $display("FAIL solid_tick: err %0d count %0d, required 0 and 1", tick_err, tick_cnt); end
  endtask

  task automatic test_bars;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    pt_t pts [5] = '{'{0, 0, 24'hFFFFFF}, '{0, 7, 24'hFFFFFF}, '{0, 8, 24'hFFFF00},
                     '{3, 56, 24'h000000}, '{35, 63, 24'h000000}};
    int bad = 0;
    pattern_sel = 2'd1;
    run_frame(-1, 2'd0);
    foreach (pts[i]) begin
      tests++;
      if (cap[pts[i].y][pts[i].x] !== pts[i].c) begin
        fails++;
        $display("FAIL bars_px(%0d,%0d): got %h, required %h", pts[i].x, pts[i].y, cap[pts[i].y][pts[i].x], pts[i].c);
      end
    end
    for (int yy = 0; yy < V; yy++)
      for (int xx = 0; xx < H; xx++)
        if (cap[yy][xx] !== bars[xx / 8]) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL bars_frame: %0d wrong pixels, required 0", bad); end
  endtask

  task automatic test_checker;
    pt_t pts [5] = '{'{0, 0, 24'hFFFFFF}, '{0, 32, 24'h000000}, '{32, 32, 24'hFFFFFF},
                     '{31, 31, 24'hFFFFFF}, '{32, 0, 24'h000000}};
    int bad = 0;
    pattern_sel = 2'd2;
    run_frame(-1, 2'd0);
    foreach (pts[i]) begin
      tests++;
      if (cap[pts[i].y][pts[i].x] !== pts[i].c) begin
        fails++;
        $display("FAIL check_px(%0d,%0d): got %h, required %h", pts[i].x, pts[i].y, cap[pts[i].y][pts[i].x], pts[i].c);
      end
    end
    for (int yy = 0; yy < V; yy++)
      for (int xx = 0; xx < H; xx++)
        if (cap[yy][xx] !== ((((xx >> 5) ^ (yy >> 5)) & 1) != 0 ? 24'h000000 : 24'hFFFFFF)) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL check_frame: %0d wrong pixels, required 0", bad); end
  endtask

  task automatic test_box;
    int ex [12] = '{8, 16, 24, 32, 40, 48, 56, 48, 40, 32, 24, 16};
    int ey [12] = '{8, 16, 24, 28, 20, 12,  4,  0,  8, 16, 24, 28};
    int mx, my, wcnt, other;
    pulse_reset();
    pattern_sel = 2'd3;
    for (int k = 0; k < 12; k++) begin
      run_frame(-1, 2'd3);
      mx = 999; my = 999; wcnt = 0; other = 0;
      for (int yy = 0; yy < V; yy++)
        for (int xx = 0; xx < H; xx++) begin
          if (cap[yy][xx] === 24'hFFFFFF) begin
            wcnt++;
            if (xx < mx) mx = xx;
            if (yy < my) my = yy;
          end else if (cap[yy][xx] !== 24'h0000FF) other++;
        end
      tests++; if (mx != ex[k]) begin fails++; $display("FAIL box_x frame %0d: got %0d, required %0d", k + 1, mx, ex[k]); end
      tests++; if (my != ey[k]) begin fails++; $display("FAIL box_y frame %0d: got %0d, required %0d", k + 1, my, ey[k]); end
      tests++; if (wcnt != 64 || other != 0) begin fails++; $display("FAIL box_shape frame %0d: white %0d other %0d, required 64 and 0", k + 1, wcnt, other); end
    end
  endtask

  task automatic test_auto;
    int exp_pat [8] = '{0, 1, 1, 2, 2, 3, 3, 0};
    int got;
    auto_cycle = 1'b0;
    pattern_sel = 2'd0;
    run_frame(-1, 2'd0);
    got = classify();
    tests++; if (got != 0) begin fails++; $display("FAIL auto_pre: pattern %0d, required 0", got); end
    auto_cycle = 1'b1;
    for (int k = 0; k < 8; k++) begin
      run_frame(-1, 2'd0);
      got = classify();
      tests++; if (got != exp_pat[k]) begin fails++; $display("FAIL auto_seq frame %0d: pattern %0d, required %0d", k + 1, got, exp_pat[k]); end
    end
  endtask

  task automatic test_manual_switch;
    int got;
    auto_cycle = 1'b0;
    pattern_sel = 2'd2;
    run_frame(10, 2'd1);
    got = classify();
    tests++; if (got != 2) begin fails++; $display("FAIL switch_load: pattern %0d, required 2", got); end
    tests++; if (cap[20][40] !== 24'h000000) begin fails++; $display("FAIL switch_midframe: px(40,20) %h, required 000000", cap[20][40]); end
    run_frame(-1, 2'd1);
    got = classify();
    tests++; if (got != 1) begin fails++; $display("FAIL switch_next: pattern %0d, required 1", got); end
    auto_cycle = 1'b1;
    run_frame(-1, 2'd1);
    got = classify();
    tests++; if (got != 1) begin fails++; $display("FAIL reauto_dwell: pattern %0d, required 1", got); end
    run_frame(-1, 2'd1);
    got = classify();
    tests++; if (got != 2) begin fails++; $display("FAIL reauto_adv: pattern %0d, required 2", got); end
  endtask

  initial begin
    h_hs[0] = 1'b1; h_hs[1] = 1'b1;
    h_vs[0] = 1'b1; h_vs[1] = 1'b1;
    h_von[0] = 1'b0; h_von[1] = 1'b0;
    h_x[0] = 0; h_x[1] = 0; h_y[0] = 0; h_y[1] = 0;
    test_reset();
    test_solid();
    test_bars();
    test_checker();
    test_box();
    test_auto();
    test_manual_switch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
